cp0_intc_timer: RTL and testbench
=================================

# cp0_intc_timer

Parametrised System Control Coprocessor 0 with an integrated interrupt controller and Count/Compare timer. It sits beside the pipeline's memory stage, where it services mfc0 and mtc0. On exception entry it captures EPC, BD and ExcCode and sets EXL. On eret it clears EXL. It raises a single interrupt request toward the pipeline's exception logic. Compared with the previous CP0 it adds a configurable number of hardware interrupt lines, a per-line edge or level latching mode, and a timer source on IP7.

## Interface
Parameters:
- NUM_HWINT, 5: number of hardware interrupt lines, legal range 1..5. Line i maps to Cause/SR bit 10+i.
- HWINT_EDGE, 0: 0 selects level mode (IP follows the registered hw_int input); 1 selects edge mode (a rising edge sets a sticky pending bit).
- PRID, 32'h1737_3552: reset and constant value of PRId.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- rd_addr, in, 5: mfc0 register number.
- rd_data, out, 32: combinational read of the addressed register. Unmapped addresses return 0.
- we, in, 1: mtc0 write enable.
- wr_addr, in, 5: mtc0 register number.
- wr_data, in, 32: mtc0 data.
- hw_int, in, NUM_HWINT: external interrupt lines.
- exc_enter, in, 1: the pipeline commits an exception or interrupt this cycle.
- exc_code, in, 5: ExcCode to record (0 means interrupt).
- exc_pc, in, 32: PC of the faulting or victim instruction.
- exc_bd, in, 1: the victim instruction sits in a branch delay slot.
- eret, in, 1: eret commits this cycle.
- int_req, out, 1: interrupt request = ie & ~exl & |(IP & IM), where the OR runs over bits 15:10.
- epc, out, 32: current EPC register.
- exl, out, 1: current SR.EXL.

## Operation
Register map:
- 9 Count: read/write.
- 11 Compare: read/write.
- 12 SR: {16'b0, IM[15:10], 8'b0, EXL, IE}.
- 13 Cause: {BD, 15'b0, IP[15:10], 3'b0, ExcCode, 2'b0}.
- 14 EPC: read/write, bits 1:0 always 0.
- 15 PRId: read-only.

Exception entry (exc_enter=1, EXL=0):
- EPC <= exc_bd ? {exc_pc[31:2],2'b0}-4 : {exc_pc[31:2],2'b0}.
- BD <= exc_bd; ExcCode <= exc_code; EXL <= 1.

Exception entry with EXL=1:
- Only ExcCode updates. EPC and BD hold (nested exception).

eret: EXL <= 0.

IP bits:
- Level mode: IP[10+i] <= hw_int[i] every cycle.
- Edge mode: a rising edge of hw_int[i] (registered previous value 0, now 1) sets IP[10+i]. The bit clears only when mtc0 writes Cause with that bit 0.
- Cause writes leave all other fields unchanged. In level mode, Cause writes are ignored entirely.
- Unused IP bits (10+NUM_HWINT..14) read 0.

Timer (IP[15] = TI):
- Count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
- An `armed` flag clears on reset and sets on any Compare write.
- TI sets on the cycle in which the incremented Count value equals Compare while armed.
- A Compare write clears TI.

Priority within one cycle:
- reset, then exc_enter, then eret, then mtc0.
- When exc_enter and we coincide, the mtc0 write is dropped.
- When exc_enter and eret coincide, EXL ends at 1.
- An mtc0 to Count loads wr_data with no increment that cycle.
- A TI set coinciding with a Compare write: the clear wins.
- An edge set coinciding with a Cause write of 0 to the same bit: the set wins.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, Count=0, Compare=0, armed=0, edge history=0. Consequently int_req=0, epc=0, exl=0.
- All state updates on the clk rising edge. rd_data and int_req are combinational from registered state.
- Read during write: rd_data returns the old value, and the new value appears the next cycle.
- Interrupt latency: a hw_int change sampled at edge N is reflected in int_req after edge N (1 cycle). In edge mode the same latency applies, measured from the first high sample.
- An mtc0 to SR that sets IE with a pending IP affects int_req from the next cycle.
- Reset asserted mid-operation clears everything immediately (asynchronously). A pending exc_enter is lost.

## Structure
- Package cp0_pkg:
  - register numbers CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15;
  - field bit positions (IM/IP base 10, TI 15, EXL 1, IE 0, BD 31);
  - ExcCode constants EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
- Sub-module cp0_timer holds Count, Compare, armed and TI.
  - Inputs: write strobes and data.
  - Outputs: count, compare, ti.
- The top level holds SR, Cause, EPC, the IP latching logic and the read mux.

## Test plan
1. Reset, then read regs 9/11/12/13/14/15 → Count is the number of cycles since reset release; 11–14 read 0; 15 reads 32'h1737_3552; int_req=0.
2. mtc0 SR=32'h0000_0401, then hw_int[0]=1 → int_req=1 exactly one cycle after sampling. Then exc_enter with exc_code=0, exc_pc=32'h3008, exc_bd=1 → EPC=32'h3004, Cause=32'h8000_0400, exl=1, int_req=0.
3. HWINT_EDGE=1: pulse hw_int[1] for one cycle → IP bit 11 stays 1. mtc0 Cause=0 → bit 11 clears. An edge on the same cycle as that write → bit 11 stays 1.
4. mtc0 Compare=20, Count=10, SR=32'h0000_8001 → TI and int_req set 10 cycles later; a Compare write clears them. Without any Compare write after reset, Count passing 0 never sets TI.
5. exc_enter with we (SR) and eret in the same cycle → SR write dropped, exl=1. Subsequent eret → exl=0, EPC unchanged.
6. Nested exception: exl=1, exc_enter with exc_code=12 → ExcCode=12; EPC and BD unchanged.

Source files
------------

// File: rtl/cp0_intc_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Purpose  : CP0 register numbers, field positions and ExcCode values
// Revision : 1.0  initial release
// ============================================================================
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int IP_BASE = 10;
  localparam int TI_BIT  = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // A delay-slot victim restarts at the branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] aligned;
    aligned = {pc[31:2], 2'b00};
    return bd ? (aligned - 32'd4) : aligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer
// Purpose  : Count/Compare timer; TI raised when Count reaches an armed Compare
// Revision : 1.0  initial release
// ============================================================================
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_armed;
  logic        r_ti;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_armed   <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= count_we ? wr_data : w_count_inc;
      if (compare_we) begin
        r_compare <= wr_data;
        r_armed   <= 1'b1;
      end
      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (compare_we)
        r_ti <= 1'b0;
      else if (r_armed && !count_we && (w_count_inc == r_compare))
        r_ti <= 1'b1;
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_intc_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_intc_timer
// Purpose  : CP0 (SR/Cause/EPC/PRId) with interrupt controller and timer on IP7
// Revision : 1.0  initial release
// ============================================================================
module cp0_intc_timer
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 5,
  parameter bit          HWINT_EDGE = 1'b0,
  parameter logic [31:0] PRID       = 32'h1737_3552
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  input  logic                 we,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exc_enter,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic                 eret,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic                 exl
);

  logic        w_mtc0;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [4:0]  w_ip_hw;
  logic [5:0]  w_ip;

  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_exl;
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  // Exception entry drops any mtc0 issued in the same cycle.
  assign w_mtc0   = we & ~exc_enter;
  assign w_wr_sr  = w_mtc0 && (wr_addr == CP0_SR);
  assign w_wr_epc = w_mtc0 && (wr_addr == CP0_EPC);

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (w_mtc0 && (wr_addr == CP0_COUNT)),
    .compare_we (w_mtc0 && (wr_addr == CP0_COMPARE)),
    .wr_data    (wr_data),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  for (genvar i = 0; i < 5; i++) begin : g_hwint
    if (i < NUM_HWINT) begin : g_used
      logic r_ip;
      if (HWINT_EDGE) begin : g_edge
        logic r_prev;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_prev <= 1'b0;
            r_ip   <= 1'b0;
          end else begin
            r_prev <= hw_int[i];
            if (hw_int[i] && !r_prev)
              r_ip <= 1'b1;
            else if (w_mtc0 && (wr_addr == CP0_CAUSE) && !wr_data[IP_BASE+i])
              r_ip <= 1'b0;
          end
        end
      end else begin : g_level
        always_ff @(posedge clk or posedge reset) begin
          if (reset)
            r_ip <= 1'b0;
          else
            r_ip <= hw_int[i];
        end
      end
      assign w_ip_hw[i] = r_ip;
    end else begin : g_unused
      assign w_ip_hw[i] = 1'b0;
    end
  end

  assign w_ip = {w_ti, w_ip_hw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else if (exc_enter) begin
      r_exc_code <= exc_code;
      // Nested entry keeps the original return context.
      if (!r_exl) begin
        r_epc <= epc_of(exc_pc, exc_bd);
        r_bd  <= exc_bd;
        r_exl <= 1'b1;
      end
    end else begin
      if (eret)
        r_exl <= 1'b0;
      else if (w_wr_sr)
        r_exl <= wr_data[EXL_BIT];
      if (w_wr_sr) begin
        r_im <= wr_data[IP_BASE+5:IP_BASE];
        r_ie <= wr_data[IE_BIT];
      end
      if (w_wr_epc)
        r_epc <= {wr_data[31:2], 2'b00};
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      CP0_COUNT:   rd_data = w_count;
      CP0_COMPARE: rd_data = w_compare;
      CP0_SR:      rd_data = {16'd0, r_im, 8'd0, r_exl, r_ie};
      CP0_CAUSE:   rd_data = {r_bd, 15'd0, w_ip, 3'd0, r_exc_code, 2'b00};
      CP0_EPC:     rd_data = r_epc;
      CP0_PRID:    rd_data = PRID;
      default:     rd_data = 32'd0;
    endcase
  end

  assign int_req = r_ie & ~r_exl & (|(w_ip & r_im));
  assign epc     = r_epc;
  assign exl     = r_exl;

endmodule
`default_nettype wire

// File: tb/tb_cp0_intc_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_intc_timer
// Purpose  : Level-mode and edge-mode CP0 instances checked against a model
// Revision : 1.0  initial release
// ============================================================================
module tb_cp0_intc_timer;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] wr_data, exc_pc;
  logic        we, exc_enter, exc_bd, eret;
  logic [4:0]  hw_int;
  logic [31:0] rd0, rd1, epc0, epc1;
  logic        ir0, ir1, exl0, exl1;

  always #5 clk = ~clk;

  cp0_intc_timer #(.NUM_HWINT(5), .HWINT_EDGE(1'b0), .PRID(32'h1737_3552)) dut_lvl (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd0), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .hw_int(hw_int), .exc_enter(exc_enter),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
    .int_req(ir0), .epc(epc0), .exl(exl0));

  cp0_intc_timer #(.NUM_HWINT(3), .HWINT_EDGE(1'b1), .PRID(32'h1737_3552)) dut_edg (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd1), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .hw_int(hw_int[2:0]), .exc_enter(exc_enter),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
    .int_req(ir1), .epc(epc1), .exl(exl1));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural state of one CP0 as software sees it.
  typedef struct {
    logic [31:0] count, compare, epc;
    bit          armed, ti, ie, exl, bd;
    logic [5:0]  im;
    logic [4:0]  code, ip, prev;
  } mstate_t;

  mstate_t ms[2];

  function automatic mstate_t mzero();
    mstate_t z;
    z.count = 0; z.compare = 0; z.epc = 0; z.armed = 0; z.ti = 0; z.ie = 0;
    z.exl = 0; z.bd = 0; z.im = 0; z.code = 0; z.ip = 0; z.prev = 0;
    return z;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit edge_mode, int nhw);
    mstate_t t = s;
    bit wr = we && !exc_enter;
    logic [31:0] inc = s.count + 32'd1;
    if (wr && wr_addr == CP0_COUNT) t.count = wr_data;
    else t.count = inc;
    if (wr && wr_addr == CP0_COMPARE) begin
      t.compare = wr_data; t.armed = 1; t.ti = 0;
    end else if (s.armed && !(wr && wr_addr == CP0_COUNT) && inc == s.compare) begin
      t.ti = 1;
    end
    for (int i = 0; i < nhw; i++) begin
      if (!edge_mode) t.ip[i] = hw_int[i];
      else begin
        if (wr && wr_addr == CP0_CAUSE && !wr_data[10+i]) t.ip[i] = 0;
        if (hw_int[i] && !s.prev[i]) t.ip[i] = 1;
        t.prev[i] = hw_int[i];
      end
    end
    if (exc_enter) begin
      t.code = exc_code;
      if (!s.exl) begin
        t.bd = exc_bd; t.exl = 1;
        t.epc = {exc_pc[31:2], 2'b00} - (exc_bd ? 32'd4 : 32'd0);
      end
    end else begin
      if (wr && wr_addr == CP0_SR) begin
        t.im = wr_data[15:10]; t.ie = wr_data[0]; t.exl = wr_data[1];
      end
      if (eret) t.exl = 0;
      if (wr && wr_addr == CP0_EPC) t.epc = {wr_data[31:2], 2'b00};
    end
    return t;
  endfunction

  function automatic logic [31:0] mread(mstate_t s, logic [4:0] a);
    case (a)
      5'd9:    return s.count;
      5'd11:   return s.compare;
      5'd12:   return {16'd0, s.im, 8'd0, s.exl, s.ie};
      5'd13:   return {s.bd, 15'd0, s.ti, s.ip, 3'd0, s.code, 2'b00};
      5'd14:   return s.epc;
      5'd15:   return 32'h1737_3552;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic mint(mstate_t s);
    return s.ie && !s.exl && (|({s.ti, s.ip} & s.im));
  endfunction

  task automatic tick();
    mstate_t nxt[2];
    nxt[0] = mstep(ms[0], 1'b0, 5);
    nxt[1] = mstep(ms[1], 1'b1, 3);
    @(posedge clk); #1;
    ms = nxt;
    check($sformatf("model_rd_lvl[%0d]", rd_addr), rd0, mread(ms[0], rd_addr));
    check($sformatf("model_rd_edg[%0d]", rd_addr), rd1, mread(ms[1], rd_addr));
    check("model_int_lvl", ir0, mint(ms[0]));
    check("model_int_edg", ir1, mint(ms[1]));
    check("model_epc_lvl", epc0, ms[0].epc);
    check("model_epc_edg", epc1, ms[1].epc);
    check("model_exl_lvl", exl0, ms[0].exl);
    check("model_exl_edg", exl1, ms[1].exl);
  endtask

  task automatic idle();
    we = 0; wr_addr = 0; wr_data = 0; exc_enter = 0; exc_code = 0;
    exc_pc = 0; exc_bd = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; wr_addr = a; wr_data = d;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  hw;
    logic        ee;
    logic [4:0]  ec;
    logic [31:0] pc;
    logic        bd;
    logic        er;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_int;
    logic        exp_exl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic w, logic [4:0] wa, logic [31:0] wd, logic [4:0] hw,
                             logic ee, logic [4:0] ec, logic [31:0] pc, logic bd,
                             logic er, logic [4:0] ra, logic [31:0] xr, logic xi, logic xe);
    vec_t r;
    r.we = w; r.wa = wa; r.wd = wd; r.hw = hw; r.ee = ee; r.ec = ec; r.pc = pc;
    r.bd = bd; r.er = er; r.ra = ra; r.exp_rd = xr; r.exp_int = xi; r.exp_exl = xe;
    return r;
  endfunction

  initial begin
    idle(); hw_int = 0; rd_addr = 0; reset = 0;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    ms[0] = mzero(); ms[1] = mzero();
    rd_addr = 12;
    #1;
    check("reset_sr", rd0, 32'd0);
    check("reset_int", {ir0, ir1}, 2'b00);
    check("reset_epc", epc0, 32'd0);
    check("reset_exl", {exl0, exl1}, 2'b00);

    //     we wa  wd             hw      ee ec     pc          bd er ra  exp_rd         int exl
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 9,  32'd1,         0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 11, 32'd0,         0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 12, 32'd0,         0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 13, 32'd0,         0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 14, 32'd0,         0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 15, 32'h1737_3552, 0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 9,  32'd7,         0, 0));
    tbl.push_back(v(1, 12, 32'h0000_0401, 5'd0, 0, 0,     0,          0, 0, 12, 32'h0000_0401, 0, 0));
    tbl.push_back(v(0, 0, 0,             5'd1, 0, 0,     0,          0, 0, 13, 32'h0000_0400, 1, 0));
    tbl.push_back(v(0, 0, 0,             5'd1, 1, 0,     32'h3008,   1, 0, 14, 32'h0000_3004, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd1, 0, 0,     0,          0, 0, 13, 32'h8000_0400, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd1, 0, 0,     0,          0, 1, 12, 32'h0000_0401, 1, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 14, 32'h0000_3004, 0, 0));
    tbl.push_back(v(1, 12, 32'h0,        5'd0, 1, 5,     32'h2000,   0, 1, 12, 32'h0000_0403, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 14, 32'h0000_2000, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 13, 32'h0000_0014, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 1, 14, 32'h0000_2000, 0, 0));
    tbl.push_back(v(0, 0, 0,             5'd0, 1, 10,    32'h100,    1, 0, 13, 32'h8000_0028, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 1, 12,    32'h700,    0, 0, 13, 32'h8000_0030, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 14, 32'h0000_00FC, 0, 1));
    tbl.push_back(v(1, 14, 32'h1234_5677, 5'd0, 0, 0,     0,          0, 0, 14, 32'h1234_5674, 0, 1));
    tbl.push_back(v(1, 13, 32'hFFFF_FFFF, 5'd0, 0, 0,     0,          0, 0, 13, 32'h8000_0030, 0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 3,  32'd0,         0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 31, 32'd0,         0, 1));
    tbl.push_back(v(1, 9, 32'h100,       5'd0, 0, 0,     0,          0, 0, 9,  32'h100,       0, 1));
    tbl.push_back(v(0, 0, 0,             5'd0, 0, 0,     0,          0, 0, 9,  32'h101,       0, 1));
    tbl.push_back(v(1, 15, 32'h0,        5'd0, 0, 0,     0,          0, 0, 15, 32'h1737_3552, 0, 1));

    foreach (tbl[i]) begin
      we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; hw_int = tbl[i].hw;
      exc_enter = tbl[i].ee; exc_code = tbl[i].ec; exc_pc = tbl[i].pc;
      exc_bd = tbl[i].bd; eret = tbl[i].er; rd_addr = tbl[i].ra;
      tick();
      check($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
      check($sformatf("vec%0d_int", i), ir0, tbl[i].exp_int);
      check($sformatf("vec%0d_exl", i), exl0, tbl[i].exp_exl);
    end

    // Read during write returns the old SR; the new one lands after the edge.
    mtc0(12, 32'h0000_8001); rd_addr = 12; hw_int = 0;
    #2 check("rdw_old_sr", rd0, 32'h0000_0403);
    tick();
    check("rdw_new_sr", rd0, 32'h0000_8001);

    // Count wrapping through 0 with Compare never written must not raise TI.
    mtc0(9, 32'hFFFF_FFFC); rd_addr = 13;
    tick(); idle();
    repeat (8) tick();
    check("unarmed_wrap_cause", rd0, 32'h8000_0030);
    check("unarmed_wrap_int", ir0, 1'b0);

    mtc0(11, 32'd20); tick();
    mtc0(9, 32'd10);  tick();
    idle();
    repeat (9) tick();
    check("timer_pre_int", ir0, 1'b0);
    tick();
    check("timer_ti_cause", rd0, 32'h8000_8030);
    check("timer_ti_int", ir0, 1'b1);
    mtc0(11, 32'd5); tick();
    check("timer_clr_cause", rd0, 32'h8000_0030);
    check("timer_clr_int", ir0, 1'b0);

    // Edge-mode sticky pending bits on the 3-line instance.
    mtc0(13, 32'd0); hw_int = 0; tick();
    check("edge_clear0", rd1[14:10], 5'b00000);
    idle(); hw_int = 5'b00010; tick();
    check("edge_set", rd1[14:10], 5'b00010);
    hw_int = 0; tick();
    check("edge_sticky", rd1[14:10], 5'b00010);
    check("lvl_follows", rd0[11], 1'b0);
    mtc0(13, 32'd0); tick();
    check("edge_cleared", rd1[14:10], 5'b00000);
    mtc0(13, 32'd0); hw_int = 5'b00010; tick();
    check("edge_set_wins", rd1[14:10], 5'b00010);
    idle(); hw_int = 5'b11111; tick();
    check("edge_unused_zero", rd1[14:10], 5'b00111);
    check("lvl_all_lines", rd0[14:10], 5'b11111);
    hw_int = 0; tick();

    // Asynchronous reset with an exception entry pending.
    idle(); exc_enter = 1; exc_code = 4; exc_pc = 32'h40; tick();
    #2 reset = 1;
    #1;
    check("areset_exl", {exl0, exl1}, 2'b00);
    check("areset_epc", epc0 | epc1, 32'd0);
    check("areset_int", {ir0, ir1}, 2'b00);
    @(posedge clk); #1;
    reset = 0; idle(); rd_addr = 9;
    ms[0] = mzero(); ms[1] = mzero();
    #1;
    check("areset_count", rd0, 32'd0);
    check("areset_exl_after", exl0, 1'b0);

    for (int k = 0; k < 1500; k++) begin
      int sel;
      idle();
      if ($urandom_range(0, 3) == 0) begin
        we = 1;
        sel = $urandom_range(0, 7);
        case (sel)
          0: wr_addr = 9;  1: wr_addr = 11; 2: wr_addr = 12; 3: wr_addr = 13;
          4: wr_addr = 14; 5: wr_addr = 15; 6: wr_addr = 5'($urandom); default: wr_addr = 12;
        endcase
        wr_data = $urandom;
        if (wr_addr == 11 && $urandom_range(0, 1) == 1)
          wr_data = ms[0].count + 32'($urandom_range(2, 40));
        if (wr_addr == 9 && $urandom_range(0, 3) == 0)
          wr_data = 32'hFFFF_FFF0;
        if (wr_addr == 12)
          wr_data[1] = ($urandom_range(0, 3) == 0);
      end
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) hw_int[b] = ~hw_int[b];
      if ($urandom_range(0, 15) == 0) begin
        exc_enter = 1; exc_code = 5'($urandom); exc_pc = $urandom; exc_bd = 1'($urandom);
      end
      eret = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) rd_addr = 5'($urandom);
      else rd_addr = 5'($urandom_range(9, 15));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
